// File: rtl/cc_fill_line_assembler.sv
// Purpose : rebuilds 512-bit cache lines from 8-beat critical-word-first memory R bursts.
// Latency : fill_valid_o rises one cycle after the completing beat.
// Backpr. : one finished line may wait in HOLD behind the output register; asm_ready_o=0 there.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   miss_wren_i/tag/idx/ofs, info_full_o  miss-info push side (issue order)
//   mem_rdata/rlast/rvalid/rready_i    observed memory R channel
//   asm_ready_o                        0 while a finished line is held (ANDed into mem_rready)
//   fill_valid_o/ready_i/tag/idx/data  line fill to the SRAM write port
//   proto_err_o                        sticky protocol error
module cc_fill_line_assembler #(
   parameter int TAG_W      = 17,
   parameter int IDX_W      = 9,
   parameter int INFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               miss_wren_i,
   input  logic [TAG_W-1:0]   miss_tag_i,
   input  logic [IDX_W-1:0]   miss_idx_i,
   input  logic [2:0]         miss_ofs_i,
   output logic               info_full_o,
   input  logic [63:0]        mem_rdata_i,
   input  logic               mem_rlast_i,
   input  logic               mem_rvalid_i,
   input  logic               mem_rready_i,
   output logic               asm_ready_o,
   output logic               fill_valid_o,
   input  logic               fill_ready_i,
   output logic [TAG_W-1:0]   fill_tag_o,
   output logic [IDX_W-1:0]   fill_idx_o,
   output logic [511:0]       fill_data_o,
   output logic               proto_err_o
);

   localparam int PTR_W  = $clog2(INFO_DEPTH);
   localparam int INFO_W = TAG_W + IDX_W + 3;
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   typedef enum logic {
      ST_ASSEMBLE = 1'b0,
      ST_HOLD     = 1'b1
   } state_t;

   // ---------------- miss-info FIFO ----------------
   logic [INFO_W-1:0] info_mem_q [INFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic              info_empty;
   logic              info_full;
   logic              info_push;
   logic              info_pop;
   logic              push_drop;
   logic [INFO_W-1:0] head;
   logic [TAG_W-1:0]  head_tag;
   logic [IDX_W-1:0]  head_idx;
   logic [2:0]        head_ofs;

   assign info_empty = (wr_ptr_q == rd_ptr_q);
   assign info_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head       = info_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign head_ofs   = head[2:0];
   assign head_idx   = head[IDX_W+2:3];
   assign head_tag   = head[INFO_W-1:IDX_W+3];

   // A pop in the same cycle frees the slot, so a push while full is still taken then.
   assign info_push  = miss_wren_i & (~info_full | info_pop);
   assign push_drop  = miss_wren_i & info_full & ~info_pop;
   assign wr_ptr_d   = info_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
   assign rd_ptr_d   = info_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

   always_ff @(posedge clk) begin
      if (info_push) begin
         info_mem_q[wr_ptr_q[PTR_W-1:0]] <= {miss_tag_i, miss_idx_i, miss_ofs_i};
      end
   end

   // ---------------- beat handling ----------------
   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [511:0]      asm_data_q, asm_data_d;
   logic [TAG_W-1:0]  hold_tag_q, hold_tag_d;
   logic [IDX_W-1:0]  hold_idx_q, hold_idx_d;
   logic              fill_valid_q, fill_valid_d;
   logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
   logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
   logic [511:0]      fill_data_q, fill_data_d;
   logic              err_q, err_d;

   logic              asm_ready;
   logic              beat;
   logic              beat_ok;
   logic              beat_orphan;
   logic              last_k;
   logic              line_done;
   logic              rlast_err;
   logic [2:0]        slot;
   logic              out_free;
   logic              load_out;

   assign asm_ready   = (state_q == ST_ASSEMBLE);
   assign beat        = mem_rvalid_i & mem_rready_i & asm_ready;
   assign beat_ok     = beat & ~info_empty;
   assign beat_orphan = beat & info_empty;
   assign last_k      = (cnt_q == 3'd7);
   // A burst ends on rlast or on its eighth beat, whichever comes first.
   assign line_done   = beat_ok & (mem_rlast_i | last_k);
   assign rlast_err   = beat_ok & (mem_rlast_i != last_k);
   assign slot        = head_ofs + cnt_q;   // wraps mod 8 by width
   assign info_pop    = line_done;
   assign out_free    = ~fill_valid_q | fill_ready_i;

   always_comb begin
      asm_data_d = asm_data_q;
      if (beat_ok) begin
         asm_data_d[{slot, 6'd0} +: 64] = mem_rdata_i;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (beat_ok) begin
         cnt_d = line_done ? 3'd0 : cnt_q + 3'd1;
      end
   end

   // Tag/index follow the line into HOLD because the FIFO head moves on at the pop.
   assign hold_tag_d = line_done ? head_tag : hold_tag_q;
   assign hold_idx_d = line_done ? head_idx : hold_idx_q;

   always_comb begin
      state_d  = state_q;
      load_out = 1'b0;
      unique case (state_q)
         ST_ASSEMBLE: begin
            if (line_done) begin
               if (out_free) load_out = 1'b1;
               else          state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (fill_ready_i) begin
               load_out = 1'b1;
               state_d  = ST_ASSEMBLE;
            end
         end
         default: state_d = ST_ASSEMBLE;
      endcase
   end

   // No beats are accepted in HOLD, so asm_data_d equals the held line there.
   always_comb begin
      fill_valid_d = fill_valid_q & ~fill_ready_i;
      fill_tag_d   = fill_tag_q;
      fill_idx_d   = fill_idx_q;
      fill_data_d  = fill_data_q;
      if (load_out) begin
         fill_valid_d = 1'b1;
         fill_data_d  = asm_data_d;
         fill_tag_d   = (state_q == ST_HOLD) ? hold_tag_q : head_tag;
         fill_idx_d   = (state_q == ST_HOLD) ? hold_idx_q : head_idx;
      end
   end

   assign err_d = err_q | push_drop | beat_orphan | rlast_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         state_q      <= ST_ASSEMBLE;
         cnt_q        <= 3'd0;
         asm_data_q   <= '0;
         hold_tag_q   <= '0;
         hold_idx_q   <= '0;
         fill_valid_q <= 1'b0;
         fill_tag_q   <= '0;
         fill_idx_q   <= '0;
         fill_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         asm_data_q   <= asm_data_d;
         hold_tag_q   <= hold_tag_d;
         hold_idx_q   <= hold_idx_d;
         fill_valid_q <= fill_valid_d;
         fill_tag_q   <= fill_tag_d;
         fill_idx_q   <= fill_idx_d;
         fill_data_q  <= fill_data_d;
         err_q        <= err_d;
      end
   end

   assign info_full_o  = info_full;
   assign asm_ready_o  = asm_ready;
   assign fill_valid_o = fill_valid_q;
   assign fill_tag_o   = fill_tag_q;
   assign fill_idx_o   = fill_idx_q;
   assign fill_data_o  = fill_data_q;
   assign proto_err_o  = err_q;

endmodule
